// File: rtl/io_irq_controller_if.sv
// io_irq_controller_if: Sys register bus, raw interrupt lines and core IntReq/IntId/IntAck handshake
interface io_irq_controller_if #(
  parameter int NUM_CH = 8,
  parameter int ID_W = $clog2(NUM_CH)
);
  logic              Sys_BlockSelect;
  logic [3:0]        Sys_RegAddress;
  logic              Sys_WrEn;
  logic              Sys_RdEn;
  logic [31:0]       Sys_WrData;
  logic [31:0]       Sys_RdData;
  logic [NUM_CH-1:0] Src_IntReq;
  logic              EIC_IntReq;
  logic [ID_W-1:0]   EIC_IntId;
  logic              EIC_IntAck;
  modport master (
    output Sys_BlockSelect, Sys_RegAddress, Sys_WrEn, Sys_RdEn, Sys_WrData, Src_IntReq, EIC_IntAck,
    input  Sys_RdData, EIC_IntReq, EIC_IntId
  );
  modport slave (
    input  Sys_BlockSelect, Sys_RegAddress, Sys_WrEn, Sys_RdEn, Sys_WrData, Src_IntReq, EIC_IntAck,
    output Sys_RdData, EIC_IntReq, EIC_IntId
  );
endinterface

// File: rtl/io_irq_controller.sv
// io_irq_controller: N-channel edge/level interrupt controller with priority arbitration and core handshake.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; default is fixed priority with ch0 highest.
module io_irq_controller #(
  parameter int NUM_CH = 8,
  parameter int ID_W = $clog2(NUM_CH),
  parameter int SYNC_EN_STAGES = 2
) (
  input logic Sys_Clock,
  input logic Sys_Reset,
  io_irq_controller_if.slave bus
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [SYNC_EN_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0] synced, dly, rise, pend, pend_n, en, mode, cand, clr, mode_chg, wd;
  logic [3:0] addr;
  logic [ID_W-1:0] sel, id;
  logic gen, req, wr, rd, acked, withdraw;
  assign addr = bus.Sys_RegAddress;
  assign wd = bus.Sys_WrData[NUM_CH-1:0];
  assign wr = bus.Sys_BlockSelect && bus.Sys_WrEn;
  assign rd = bus.Sys_BlockSelect && bus.Sys_RdEn;
  assign synced = sync_q[SYNC_EN_STAGES-1];
  assign rise = synced & ~dly;
  assign acked = state == REQ && bus.EIC_IntAck;
  assign mode_chg = wr && addr == 4'h3 ? wd ^ mode : '0;
  assign clr = (wr && addr == 4'h2 ? wd : '0) | (acked ? NUM_CH'(1) << id : '0);
  // Edge channels latch until cleared (a new rise beats a clear); level channels follow the line.
  assign pend_n = ~mode_chg & ((mode & (rise | (pend & ~clr))) | (~mode & synced));
  assign cand = pend & en;
  assign withdraw = !gen || !en[id] || (!mode[id] && !pend[id]);
`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr;
  always_comb begin
    int j;
    j = 0;
    sel = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = j >= NUM_CH ? j - NUM_CH : j;
      sel = cand[j] ? ID_W'(j) : sel;
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) sel = cand[i] ? ID_W'(i) : sel;
  end
`endif
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      sync_q <= '0;
      dly <= '0;
      pend <= '0;
      gen <= 1'b0;
      en <= '0;
      mode <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_EN_STAGES-2:0], bus.Src_IntReq};
      dly <= synced;
      pend <= pend_n;
      gen <= wr && addr == 4'h0 ? bus.Sys_WrData[0] : gen;
      en <= wr && addr == 4'h1 ? wd : en;
      mode <= wr && addr == 4'h3 ? wd : mode;
    end
  end
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state <= IDLE;
      req <= 1'b0;
      id <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr <= '0;
`endif
    end else if (state == IDLE) begin
      if (gen && |cand) begin
        state <= REQ;
        req <= 1'b1;
        id <= sel;
      end
    end else if (acked || withdraw) begin
      state <= IDLE;
      req <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      if (acked) ptr <= int'(id) == NUM_CH - 1 ? '0 : id + 1'b1;
`endif
    end
  end
  assign bus.EIC_IntReq = req;
  assign bus.EIC_IntId = id;
  assign bus.Sys_RdData = !rd ? '0 :
                          addr == 4'h0 ? {31'b0, gen} :
                          addr == 4'h1 ? 32'(en) :
                          addr == 4'h2 ? 32'(pend) :
                          addr == 4'h3 ? 32'(mode) :
                          addr == 4'h4 ? {req, 31'(id)} : '0;
endmodule

// File: tb/tb_io_irq_controller.sv
// tb_io_irq_controller: scoreboard bench; expected grant IDs are queued at stimulus and popped on each IntReq rise.
module tb_io_irq_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int sb[$];
  int exp_id;
  logic prev_req = 1'b0;
  io_irq_controller_if #(.NUM_CH(8)) bus ();
  io_irq_controller dut (.Sys_Clock(clk), .Sys_Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.Sys_BlockSelect = 1'b1;
    bus.Sys_WrEn = 1'b1;
    bus.Sys_RegAddress = a;
    bus.Sys_WrData = d;
    tick(1);
    bus.Sys_BlockSelect = 1'b0;
    bus.Sys_WrEn = 1'b0;
  endtask
  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.Sys_BlockSelect = 1'b1;
    bus.Sys_RdEn = 1'b1;
    bus.Sys_RegAddress = a;
    #1 d = bus.Sys_RdData;
    bus.Sys_BlockSelect = 1'b0;
    bus.Sys_RdEn = 1'b0;
    chk(tag, d, exp);
  endtask
  task automatic ack();
    bus.EIC_IntAck = 1'b1;
    tick(1);
    bus.EIC_IntAck = 1'b0;
  endtask
  task automatic wait_req(input string tag, input logic lvl);
    int n = 0;
    while (bus.EIC_IntReq !== lvl && n < 20) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(bus.EIC_IntReq), 32'(lvl));
  endtask
  task automatic init(input logic [7:0] m, input logic [7:0] e);
    bus.Src_IntReq = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    wr(4'h3, 32'(m));
    wr(4'h1, 32'(e));
    wr(4'h0, 32'h1);
  endtask
  always @(negedge clk) begin
    if (bus.EIC_IntReq === 1'b1 && !prev_req) begin
      if (sb.size() == 0) chk("unexpected_req", 32'h1, 32'h0);
      else begin
        exp_id = sb.pop_front();
        chk("grant_id", 32'(bus.EIC_IntId), 32'(exp_id));
      end
    end
    prev_req = bus.EIC_IntReq === 1'b1;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.Sys_BlockSelect = 1'b0;
    bus.Sys_RegAddress = '0;
    bus.Sys_WrEn = 1'b0;
    bus.Sys_RdEn = 1'b0;
    bus.Sys_WrData = '0;
    bus.Src_IntReq = '0;
    bus.EIC_IntAck = 1'b0;
    tick(3);
    chk("rst_req", 32'(bus.EIC_IntReq), 32'h0);
    chk("rst_id", 32'(bus.EIC_IntId), 32'h0);
    chk("rst_rdata_unsel", bus.Sys_RdData, 32'h0);
    rst = 1'b0;
    tick(1);
    chk_reg("rst_ctrl", 4'h0, 32'h0);
    chk_reg("rst_pending", 4'h2, 32'h0);
    chk_reg("rst_status", 4'h4, 32'h0);
    // Edge capture and raw-to-request latency
    init(8'hFF, 8'h04);
    chk("unsel_rdata", bus.Sys_RdData, 32'h0);
    chk_reg("ctrl", 4'h0, 32'h1);
    sb.push_back(2);
    bus.Src_IntReq = 8'h04;
    tick(1);
    bus.Src_IntReq = '0;
    tick(2);
    chk("edge_lat_pre", 32'(bus.EIC_IntReq), 32'h0);
    tick(1);
    chk("edge_lat", 32'(bus.EIC_IntReq), 32'h1);
    chk_reg("edge_pending", 4'h2, 32'h04);
    chk_reg("edge_status", 4'h4, 32'h8000_0002);
    ack();
    chk("edge_ack_req", 32'(bus.EIC_IntReq), 32'h0);
    chk_reg("edge_ack_pending", 4'h2, 32'h0);
    // Priority: simultaneous ch1 and ch5
    init(8'hFF, 8'hFF);
    sb.push_back(1);
    sb.push_back(5);
    bus.Src_IntReq = 8'h22;
    tick(1);
    bus.Src_IntReq = '0;
    wait_req("prio_req1", 1'b1);
    ack();
    chk("prio_gap", 32'(bus.EIC_IntReq), 32'h0);
    wait_req("prio_req2", 1'b1);
    ack();
    chk_reg("prio_pending", 4'h2, 32'h0);
    // Masking withdraws without touching pending
    init(8'hFF, 8'hFF);
    sb.push_back(3);
    bus.Src_IntReq = 8'h08;
    tick(1);
    bus.Src_IntReq = '0;
    wait_req("mask_req", 1'b1);
    wr(4'h1, 32'hF7);
    chk("mask_hold", 32'(bus.EIC_IntReq), 32'h1);
    tick(1);
    chk("mask_withdraw", 32'(bus.EIC_IntReq), 32'h0);
    chk_reg("mask_pending", 4'h2, 32'h08);
    sb.push_back(3);
    wr(4'h1, 32'hFF);
    wait_req("mask_rereq", 1'b1);
    ack();
    chk_reg("mask_ack_pending", 4'h2, 32'h0);
    // Level mode on ch0
    init(8'hFE, 8'hFF);
    sb.push_back(0);
    sb.push_back(0);
    bus.Src_IntReq = 8'h01;
    wait_req("lvl_req1", 1'b1);
    ack();
    wait_req("lvl_req2", 1'b1);
    wr(4'h2, 32'h1);
    chk_reg("lvl_w1c_pending", 4'h2, 32'h01);
    chk("lvl_w1c_req", 32'(bus.EIC_IntReq), 32'h1);
    bus.Src_IntReq = '0;
    wait_req("lvl_drop", 1'b0);
    chk_reg("lvl_drop_pending", 4'h2, 32'h0);
    // Set beats W1C on ch4
    init(8'hFF, 8'hFF);
    wr(4'h0, 32'h0);
    bus.Src_IntReq = 8'h10;
    tick(1);
    bus.Src_IntReq = '0;
    tick(3);
    chk_reg("svc_pending1", 4'h2, 32'h10);
    bus.Src_IntReq = 8'h10;
    tick(1);
    bus.Src_IntReq = '0;
    tick(1);
    wr(4'h2, 32'h10);
    chk_reg("svc_set_wins", 4'h2, 32'h10);
    wr(4'h2, 32'h10);
    chk_reg("svc_w1c", 4'h2, 32'h0);
    // Two level channels continuously pending: grant order depends on arbitration mode
    init(8'hFC, 8'h03);
`ifdef IRQ_ROUND_ROBIN_EN
    sb.push_back(0); sb.push_back(1); sb.push_back(0);
`else
    sb.push_back(0); sb.push_back(0); sb.push_back(0);
`endif
    bus.Src_IntReq = 8'h03;
    for (int i = 0; i < 3; i++) begin
      wait_req("arb_req", 1'b1);
      if (i < 2) ack();
      else begin
        bus.Src_IntReq = '0;
        wr(4'h0, 32'h0);
      end
    end
    tick(1);
    chk("arb_gen_off", 32'(bus.EIC_IntReq), 32'h0);
    tick(5);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
